// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO-draining serial transmitter.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/fifo_drain_tx_bit_timer.sv
// Bit-period timer: pulses tick on the last clock of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = ~clear & (cnt == LAST);

    // Reload at the bit boundary so the count never wraps mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (clear)        cnt <= '0;
        else if (cnt == LAST)  cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_drain_tx.sv
// Pops bytes from an upstream FIFO and sends each as a 10-bit serial frame.
module fifo_drain_tx
    import fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 empty,
    input  logic [DATA_W-1:0]    rdata,
    output logic                 read,
    output logic                 txd,
    output logic                 busy,
    output logic [1:0]           diag_state,
    output logic [2:0]           diag_bitcnt
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    state_t              state, state_nx;
    logic [DATA_W-1:0]   sh, sh_nx;
    logic [2:0]          bitcnt, bitcnt_nx;
    logic                txd_q, txd_nx;
    logic                tick;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // Popping moves us out of IDLE on the same edge, so read lasts one cycle
    assign read        = (state == IDLE) & en & ~empty & rst;
    assign txd         = txd_q;
    assign busy        = (state != IDLE);
    assign diag_state  = state;
    assign diag_bitcnt = bitcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sh     <= '0;
            bitcnt <= '0;
            txd_q  <= 1'b1;
        end else begin
            state  <= state_nx;
            sh     <= sh_nx;
            bitcnt <= bitcnt_nx;
            txd_q  <= txd_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sh_nx     = sh;
        bitcnt_nx = bitcnt;
        txd_nx    = txd_q;
        case (state)
            IDLE: begin
                txd_nx = 1'b1;
                if (read) begin
                    state_nx = START;
                    sh_nx    = rdata;
                    txd_nx   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nx  = DATA;
                    bitcnt_nx = '0;
                    txd_nx    = sh[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == LAST_BIT) begin
                        state_nx  = STOP;
                        bitcnt_nx = '0;
                        txd_nx    = 1'b1;
                    end else begin
                        // Shift so the next bit to send is always at sh[0]
                        bitcnt_nx = bitcnt + 1'b1;
                        sh_nx     = sh >> 1;
                        txd_nx    = sh[1];
                    end
                end
            end
            STOP: begin
                txd_nx = 1'b1;
                if (tick) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Self-checking bench for fifo_drain_tx against a frame-position reference model.
module tb_fifo_drain_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       empty;
    logic [7:0] rdata;
    logic       read;
    logic       txd;
    logic       busy;
    logic [1:0] diag_state;
    logic [2:0] diag_bitcnt;

    fifo_drain_tx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .empty       (empty),
        .rdata       (rdata),
        .read        (read),
        .txd         (txd),
        .busy        (busy),
        .diag_state  (diag_state),
        .diag_bitcnt (diag_bitcnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: a frame is 10 bit slots of C cycles: start, 8 data LSB first, stop
    logic       m_in;
    int         m_pos;
    logic [7:0] m_byte;
    logic [7:0] fq[$];

    int cyc = 0;
    int rd_cnt = 0;
    int busy_cnt = 0;
    int last_rd = -1;
    bit chk_gap = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        empty = (fq.size() == 0);
        rdata = empty ? 8'($urandom) : fq[0];
    endtask

    task automatic tick();
        logic e_txd, e_busy, e_rd, rd_seen;
        logic [1:0] e_st;
        logic [2:0] e_bc;
        int b;
        #4;
        if (!m_in) begin
            e_txd = 1'b1; e_busy = 1'b0; e_st = 2'd0; e_bc = 3'd0;
        end else begin
            b = m_pos / C;
            e_busy = 1'b1;
            e_txd  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_byte[b-1];
            e_st   = (b == 0) ? 2'd1 : (b == 9) ? 2'd3 : 2'd2;
            e_bc   = (b >= 1 && b <= 8) ? 3'(b - 1) : 3'd0;
        end
        e_rd = rst && !m_in && en && !empty;
        chk("txd", 32'(txd), 32'(e_txd));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("read", 32'(read), 32'(e_rd));
        chk("diag_state", 32'(diag_state), 32'(e_st));
        chk("diag_bitcnt", 32'(diag_bitcnt), 32'(e_bc));
        rd_seen = read;
        if (busy) busy_cnt++;
        if (rd_seen) begin
            rd_cnt++;
            if (chk_gap && last_rd >= 0) chk("read_gap", 32'(cyc - last_rd), 32'(10*C + 1));
            last_rd = cyc;
        end
        @(posedge clk);
        if (!rst) m_in = 1'b0;
        else if (m_in) begin
            m_pos++;
            if (m_pos == 10*C) m_in = 1'b0;
        end else if (e_rd) begin
            m_in = 1'b1; m_pos = 0; m_byte = rdata;
        end
        if (rd_seen && fq.size() > 0) void'(fq.pop_front());
        cyc++;
        #1;
        drive_fifo();
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; empty = 1'b1; rdata = 8'h00;
        m_in = 1'b0; m_pos = 0; m_byte = 8'h00;
        @(posedge clk); #1;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom);
            fq.push_back(8'($urandom));
            drive_fifo();
            tick();
        end
        fq.delete();
        drive_fifo();

        // Single byte A5
        rst = 1'b1; en = 1'b1;
        rd_cnt = 0; busy_cnt = 0;
        fq.push_back(8'hA5); drive_fifo();
        for (int i = 0; i < 45; i++) tick();
        chk("single_reads", 32'(rd_cnt), 32'd1);
        chk("single_busy", 32'(busy_cnt), 32'(10*C));

        // Full FIFO: four back-to-back frames
        rd_cnt = 0; chk_gap = 1; last_rd = -1;
        for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
        drive_fifo();
        for (int i = 0; i < 4*(10*C+1) + 20; i++) tick();
        chk("full_reads", 32'(rd_cnt), 32'd4);
        chk_gap = 0;

        // Enable gating
        en = 1'b0; rd_cnt = 0;
        fq.push_back(8'h5A); drive_fifo();
        for (int i = 0; i < 50; i++) tick();
        chk("en_off_reads", 32'(rd_cnt), 32'd0);
        en = 1'b1;
        n = 0;
        while (!(m_in && m_pos == 3*C) && n < 100) begin tick(); n++; end
        chk("reach_data", 32'(n < 100), 32'd1);
        en = 1'b0;
        fq.push_back(8'h77); drive_fifo();
        for (int i = 0; i < 80; i++) tick();
        chk("en_drop_reads", 32'(rd_cnt), 32'd1);
        en = 1'b1;
        tick();
        chk("en_resume_reads", 32'(rd_cnt), 32'd2);
        for (int i = 0; i < 10*C + 2; i++) tick();

        // Reset in the middle of data bit 3
        fq.delete();
        fq.push_back(8'hC3); drive_fifo();
        n = 0;
        while (!(m_in && m_pos == 4*C + 1) && n < 100) begin tick(); n++; end
        chk("reach_bit3", 32'(n < 100), 32'd1);
        chk("pre_rst_bitcnt", 32'(diag_bitcnt), 32'd3);
        #3 rst = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_state", 32'(diag_state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_bitcnt", 32'(diag_bitcnt), 32'd0);
        m_in = 1'b0;
        fq.push_back(8'h3C); drive_fifo();
        tick();
        rst = 1'b1; rd_cnt = 0;
        tick();
        chk("post_rst_read", 32'(rd_cnt), 32'd1);
        for (int i = 0; i < 10*C + 2; i++) tick();

        // Starved
        fq.delete(); drive_fifo();
        rd_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            en = 1'($urandom);
            tick();
        end
        chk("starve_reads", 32'(rd_cnt), 32'd0);
        chk("starve_busy", 32'(busy_cnt), 32'd0);

        // Random traffic with enable flicker
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) fq.push_back(8'($urandom));
            drive_fifo();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
